// File: rtl/sw_max_score_collector.sv
// rtl/sw_max_score_collector.sv - running max score and first-occurrence coordinate over a row-major SW matrix
// Optional SW_HIT_COUNT_EN adds a threshold input and a hit_count output.
module sw_max_score_collector #(
  parameter int SCORE_W = 10,
  parameter int ROWS    = 16,
  parameter int COLS    = 16,
  parameter int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int COL_W   = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               score_valid,
  input  logic [SCORE_W-1:0] score,
  output logic               score_ready,
  output logic               busy,
  output logic               result_valid,
  input  logic               result_ack,
`ifdef SW_HIT_COUNT_EN
  input  logic [SCORE_W-1:0] threshold,
  output logic [ROW_W+COL_W:0] hit_count,
`endif
  output logic [SCORE_W-1:0] max_score,
  output logic [ROW_W-1:0]   max_row,
  output logic [COL_W-1:0]   max_col
);

  typedef enum logic [1:0] {IDLE, COLLECT, REPORT} state_t;

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  state_t           state;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             last_col;
  logic             last_cell;

  assign last_col  = (col == COL_LAST);
  assign last_cell = last_col && (row == ROW_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      score_ready  <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      max_score    <= '0;
      max_row      <= '0;
      max_col      <= '0;
      row          <= '0;
      col          <= '0;
`ifdef SW_HIT_COUNT_EN
      hit_count    <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state       <= COLLECT;
            score_ready <= 1'b1;
            busy        <= 1'b1;
            max_score   <= '0;
            max_row     <= '0;
            max_col     <= '0;
            row         <= '0;
            col         <= '0;
`ifdef SW_HIT_COUNT_EN
            hit_count   <= '0;
`endif
          end
        end
        COLLECT: begin
          if (score_valid) begin
            // Strict compare keeps the earliest coordinate on ties.
            if (score > max_score) begin
              max_score <= score;
              max_row   <= row;
              max_col   <= col;
            end
`ifdef SW_HIT_COUNT_EN
            if (score >= threshold)
              hit_count <= hit_count + (ROW_W+COL_W+1)'(1);
`endif
            if (last_cell) begin
              state        <= REPORT;
              score_ready  <= 1'b0;
              result_valid <= 1'b1;
              row          <= '0;
              col          <= '0;
            end else if (last_col) begin
              col <= '0;
              row <= row + ROW_W'(1);
            end else begin
              col <= col + COL_W'(1);
            end
          end
        end
        REPORT: begin
          if (result_ack) begin
            state        <= IDLE;
            result_valid <= 1'b0;
            busy         <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          score_ready  <= 1'b0;
          busy         <= 1'b0;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sw_max_score_collector.sv
// tb/tb_sw_max_score_collector.sv - randomized self-checking bench for sw_max_score_collector (4x4)
module tb_sw_max_score_collector;

  localparam int SW = 10;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int N  = R * C;
  localparam int RW = 2;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          score_valid;
  logic [SW-1:0] score;
  logic          score_ready;
  logic          busy;
  logic          result_valid;
  logic          result_ack;
  logic [SW-1:0] max_score;
  logic [RW-1:0] max_row;
  logic [CW-1:0] max_col;
`ifdef SW_HIT_COUNT_EN
  logic [SW-1:0]    threshold;
  logic [RW+CW:0]   hit_count;
`endif

  sw_max_score_collector #(.SCORE_W(SW), .ROWS(R), .COLS(C)) dut (
    .clk(clk), .rst(rst), .start(start),
    .score_valid(score_valid), .score(score), .score_ready(score_ready),
    .busy(busy), .result_valid(result_valid), .result_ack(result_ack),
`ifdef SW_HIT_COUNT_EN
    .threshold(threshold), .hit_count(hit_count),
`endif
    .max_score(max_score), .max_row(max_row), .max_col(max_col)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int m[N];
  int thr = 0;
  int exp_ms, exp_mr, exp_mc, exp_hc;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: scan the cell list in row-major order, first strict maximum wins.
  task automatic model();
    exp_ms = 0; exp_mr = 0; exp_mc = 0; exp_hc = 0;
    for (int i = 0; i < N; i++) begin
      if (m[i] > exp_ms) begin
        exp_ms = m[i];
        exp_mr = i / C;
        exp_mc = i % C;
      end
      if (m[i] >= thr) exp_hc++;
    end
  endtask

  task automatic do_start();
`ifdef SW_HIT_COUNT_EN
    threshold = SW'(thr);
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", int'(busy), 1);
    check("start_ready", int'(score_ready), 1);
    check("start_rvalid", int'(result_valid), 0);
    check("start_max_clr", int'(max_score), 0);
`ifdef SW_HIT_COUNT_EN
    check("start_hit_clr", int'(hit_count), 0);
`endif
  endtask

  task automatic feed(input bit gaps, input int stop_after);
    int idx = 0;
    int budget = 0;
    bit v;
    while (idx < stop_after && budget < 500) begin
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      score_valid = v;
      score = v ? SW'(m[idx]) : SW'($urandom_range(0, 1023));
      start = gaps ? ($urandom_range(0, 3) == 0) : 1'b0;
      check("ready_collect", int'(score_ready), 1);
      if (idx == N - 1) check("rvalid_early", int'(result_valid), 0);
      tick();
      if (v) idx++;
      budget++;
    end
    score_valid = 1'b0;
    start = 1'b0;
    if (idx < stop_after) check("feed_timeout", idx, stop_after);
  endtask

  task automatic check_result(input string tag);
    model();
    check({tag, "_rvalid"}, int'(result_valid), 1);
    check({tag, "_busy"}, int'(busy), 1);
    check({tag, "_ready"}, int'(score_ready), 0);
    check({tag, "_max"}, int'(max_score), exp_ms);
    check({tag, "_row"}, int'(max_row), exp_mr);
    check({tag, "_col"}, int'(max_col), exp_mc);
`ifdef SW_HIT_COUNT_EN
    check({tag, "_hits"}, int'(hit_count), exp_hc);
`endif
  endtask

  task automatic finish_report(input int hold);
    for (int i = 0; i < hold; i++) begin
      result_ack  = 1'b0;
      score_valid = 1'($urandom_range(0, 1));
      score       = SW'($urandom_range(0, 1023));
      start       = 1'($urandom_range(0, 1));
      tick();
      check("hold_rvalid", int'(result_valid), 1);
      check("hold_max", int'(max_score), exp_ms);
    end
    score_valid = 1'b0;
    start = 1'b0;
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    check("ack_rvalid", int'(result_valid), 0);
    check("ack_busy", int'(busy), 0);
    check("ack_retain", int'(max_score), exp_ms);
    score_valid = 1'b1;
    score = SW'(1023);
    result_ack = 1'b1;
    tick();
    tick();
    score_valid = 1'b0;
    result_ack = 1'b0;
    check("idle_ready", int'(score_ready), 0);
    check("idle_retain_max", int'(max_score), exp_ms);
    check("idle_retain_row", int'(max_row), exp_mr);
  endtask

  task automatic run_matrix(input string tag, input bit gaps, input int hold);
    do_start();
    feed(gaps, N);
    check_result(tag);
    finish_report(hold);
  endtask

  task automatic fill_random(input int hi);
    for (int i = 0; i < N; i++) m[i] = $urandom_range(0, hi);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; score_valid = 1'b0; score = '0; result_ack = 1'b0;
`ifdef SW_HIT_COUNT_EN
    threshold = '0;
`endif
    tick();
    tick();
    check("rst_ready", int'(score_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_rvalid", int'(result_valid), 0);
    check("rst_max", int'(max_score), 0);
    check("rst_row", int'(max_row), 0);
    check("rst_col", int'(max_col), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < N; i++) m[i] = 0;
    thr = 1;
    run_matrix("zeros", 1'b0, 0);

    fill_random(36);
    m[2*C+1] = 37;
    thr = $urandom_range(0, 40);
    run_matrix("peak37", 1'b0, 10);

    fill_random(49);
    m[3] = 50;
    m[3*C] = 50;
    run_matrix("tie50", 1'b0, 2);

    fill_random(1022);
    m[N-1] = 1023;
    run_matrix("last1023", 1'b0, 1);

    for (int k = 0; k < 4; k++) begin
      fill_random(1023);
      thr = $urandom_range(0, 1023);
      run_matrix("gapped", 1'b1, $urandom_range(0, 5));
    end

    fill_random(1023);
    do_start();
    feed(1'b0, 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_ready", int'(score_ready), 0);
    check("abort_rvalid", int'(result_valid), 0);
    check("abort_max", int'(max_score), 0);
    check("abort_row", int'(max_row), 0);
    check("abort_col", int'(max_col), 0);
    fill_random(500);
    run_matrix("after_abort", 1'b1, 3);

    for (int i = 0; i < N; i++) m[i] = i % 16;
    m[1] = 20; m[6] = 25; m[9] = 31; m[12] = 200; m[15] = 21;
    thr = 20;
    run_matrix("hits", 1'b0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

endmodule

// File: doc/sw_max_score_collector.md
Name: sw_max_score_collector

Overview:
- Downstream stage of the SW scoring array: consumes the per-cell 10-bit similarity scores streamed in row-major order.
- Tracks the running maximum score and the matrix coordinate (row, col) where it first occurs.
- On completion of a full matrix, presents the result under a valid/ack handshake for the traceback stage and host readout.

Parameters:
- SCORE_W, 10, width of incoming cell score and reported maximum (unsigned).
- ROWS, 16, number of matrix rows (query length), >= 1.
- COLS, 16, number of matrix columns (reference length), >= 1.
- ROW_W, $clog2(ROWS) (min 1), width of row index.
- COL_W, $clog2(COLS) (min 1), width of column index.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a new matrix; honoured only in IDLE.
- score_valid  in  1  score carries a valid cell value.
- score  in  SCORE_W  cell score, unsigned.
- score_ready  out  1  high in COLLECT only; a cell is accepted when score_valid && score_ready.
- busy  out  1  high in COLLECT or REPORT.
- result_valid  out  1  high in REPORT; result outputs stable while high.
- result_ack  in  1  consumer accepts result; effective only while result_valid.
- max_score  out  SCORE_W  maximum accepted score of the current/last matrix.
- max_row  out  ROW_W  row of first occurrence of max_score.
- max_col  out  COL_W  column of first occurrence of max_score.

Behaviour:
- Reset: synchronous, active-high; state=IDLE; score_ready, busy, result_valid = 0; max_score, max_row, max_col = 0; internal row/col counters = 0. Reset mid-COLLECT or mid-REPORT aborts; no result emitted.
- States: IDLE, COLLECT, REPORT.
- IDLE: start=1 -> next cycle COLLECT, counters cleared, max_score/max_row/max_col cleared to 0. score_valid ignored.
- COLLECT: score_ready=1. On accept: if score > max_score (strict), max_score<=score, max_row<=row, max_col<=col, all in the same edge. Ties keep the earliest coordinate. col increments; at col==COLS-1, col wraps to 0 and row increments.
- Last cell (row==ROWS-1, col==COLS-1) accepted -> next cycle REPORT, result_valid=1, outputs include last cell's contribution (latency 1 cycle from last accept to result_valid). Counters return to 0.
- REPORT: score_ready=0; result_valid held until result_ack=1; then next cycle IDLE, result_valid=0. Result registers retain values in IDLE until next start.
- start outside IDLE ignored (no restart). result_ack outside REPORT ignored.
- score_valid with score_ready=0 is dropped, not buffered; upstream must honour score_ready.
- All-zero matrix: max_score=0, max_row=0, max_col=0.
- ROWS=1 or COLS=1 handled: wrap logic degenerates correctly; 1x1 matrix goes COLLECT->REPORT after one accept.
- No arithmetic beyond unsigned compare; no saturation needed (input already bounded by SCORE_W).

Optional Feature:
- Macro: SW_HIT_COUNT_EN.
- Defined: adds input threshold (SCORE_W) and output hit_count (ROW_W+COL_W+1 bits). hit_count cleared on reset and on accepted start; increments on every accepted cell with score >= threshold; stable during REPORT and IDLE. threshold sampled per accepted cell.
- Not defined: ports absent, no counter logic; all other behaviour identical.

Test Plan:
- ROWS=4, COLS=4: reset, start, stream 16 cells all 0 -> result_valid exactly 1 cycle after 16th accept; max_score=0, max_row=0, max_col=0.
- ROWS=4, COLS=4: score 37 at (2,1), all others <37 -> max_score=37, max_row=2, max_col=1; result held while result_ack=0 for 10 cycles; ack -> IDLE, busy=0 next cycle.
- Ties: 50 at (0,3) and (3,0), others smaller -> max_row=0, max_col=3; separately 1023 at last cell (3,3) -> max_score=1023, (3,3).
- Gapped stream: score_valid toggled randomly, score_valid pulses during IDLE/REPORT and start pulses during COLLECT -> exactly 16 accepts counted, extra start ignored, result matches reference model.
- Reset asserted after 7 accepts -> next cycle all outputs 0, IDLE; new start plus 16 cells yields correct fresh result, no carry-over.
- SW_HIT_COUNT_EN defined, threshold=20, scores 0..15 x2 per row pattern with five cells >=20 -> hit_count=5 in REPORT; next start clears to 0.
